gin_bus_ctrl: RTL



---
 rtl/gin_pkg.sv | 32 +++
 rtl/psum_ret_fifo.sv | 47 ++++
 rtl/gin_bus_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gin_pkg.sv
// Shared types and constants for the GIN bus-side controller.
package gin_pkg;

  typedef enum logic [1:0] {
    PKT_IFMAP   = 2'd0,
    PKT_FLTR    = 2'd1,
    PKT_PSUM    = 2'd2,
    PKT_ILLEGAL = 2'd3
  } pkt_type_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } gin_state_e;

  localparam logic [2:0] CEN_NONE  = 3'b000;
  localparam logic [2:0] CEN_IFMAP = 3'b001;
  localparam logic [2:0] CEN_FLTR  = 3'b010;
  localparam logic [2:0] CEN_PSUM  = 3'b100;

  function automatic logic [2:0] cen_of(input pkt_type_e t);
    logic [2:0] cen;
    case (t)
      PKT_IFMAP: cen = CEN_IFMAP;
      PKT_FLTR:  cen = CEN_FLTR;
      PKT_PSUM:  cen = CEN_PSUM;
      default:   cen = CEN_NONE;
    endcase
    return cen;
  endfunction

endpackage

// File: rtl/psum_ret_fifo.sv
// Return-psum FIFO: head visible combinationally, push/pop take effect on the next edge.
// A push while full is only written when a pop happens in the same cycle.
module psum_ret_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  // Extra MSB on each pointer separates the full and empty cases.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/gin_bus_ctrl.sv
// Bus master toward the multicaster row: one-cycle registered launch, 1 packet/cycle when casters ready.
// s_ready stalls while a driven packet waits for caster_ready; the psum return path never backpressures.
module gin_bus_ctrl
  import gin_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int TIMEOUT    = 64,
  parameter int RET_DEPTH  = 4,
  localparam int TAG_W     = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [1:0]              s_type,
  input  logic [TAG_W-1:0]        s_tag,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  output logic [DATA_WIDTH-1:0]   ifmap_data_B2M,
  output logic [DATA_WIDTH-1:0]   fltr_data_B2M,
  output logic [2*DATA_WIDTH-1:0] psum_data_B2M,
  output logic [TAG_W-1:0]        tag_out,
  output logic [2:0]              caster_en,
  input  logic                    caster_ready,
  input  logic                    caster_valid,
  input  logic [2*DATA_WIDTH-1:0] psum_data_M2B,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    busy,
  input  logic                    err_clr,
  output logic                    err_type,
  output logic                    err_timeout,
  output logic                    err_ovf
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  gin_state_e              r_state;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic [DATA_WIDTH-1:0]   r_ifmap;
  logic [DATA_WIDTH-1:0]   r_fltr;
  logic [2*DATA_WIDTH-1:0] r_psum;
  logic [TAG_W-1:0]        r_tag;
  logic [2:0]              r_cen;
  logic                    r_err_type;
  logic                    r_err_timeout;
  logic                    r_err_ovf;

  pkt_type_e               w_type;
  logic                    w_s_ready;
  logic                    w_accept;
  logic                    w_legal_acc;
  logic                    w_illegal_acc;
  logic                    w_timeout;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_ovf;
  logic [2*DATA_WIDTH-1:0] w_head;

  assign w_type        = pkt_type_e'(s_type);
  assign w_s_ready     = !rst && ((r_state == ST_IDLE) || caster_ready);
  assign w_accept      = s_valid && w_s_ready;
  assign w_legal_acc   = w_accept && (w_type != PKT_ILLEGAL);
  assign w_illegal_acc = w_accept && (w_type == PKT_ILLEGAL);
  // caster_ready on the final waiting cycle still completes the transfer.
  assign w_timeout     = (TIMEOUT > 0) && (r_state == ST_DRIVE) && !caster_ready &&
                         (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_ifmap    <= '0;
      r_fltr     <= '0;
      r_psum     <= '0;
      r_tag      <= '0;
      r_cen      <= CEN_NONE;
    end else if (w_legal_acc) begin
      r_state    <= ST_DRIVE;
      r_wait_cnt <= '0;
      r_tag      <= s_tag;
      r_cen      <= cen_of(w_type);
      case (w_type)
        PKT_IFMAP: r_ifmap <= s_data[DATA_WIDTH-1:0];
        PKT_FLTR:  r_fltr  <= s_data[DATA_WIDTH-1:0];
        PKT_PSUM:  r_psum  <= s_data;
        default:   r_psum  <= r_psum;
      endcase
    end else if (r_state == ST_DRIVE) begin
      if (caster_ready || w_timeout) begin
        r_state    <= ST_IDLE;
        r_cen      <= CEN_NONE;
        r_wait_cnt <= '0;
      end else if (TIMEOUT > 0) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  psum_ret_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (RET_DEPTH)
  ) u_ret_fifo (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_push     (caster_valid),
    .i_push_dat (psum_data_M2B),
    .i_pop      (m_ready),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_pop = m_ready && !w_empty;
  assign w_ovf = caster_valid && w_full && !w_pop;

  // Set beats clear so an event coinciding with err_clr is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_type    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_ovf     <= 1'b0;
    end else begin
      r_err_type    <= w_illegal_acc | (r_err_type    & ~err_clr);
      r_err_timeout <= w_timeout     | (r_err_timeout & ~err_clr);
      r_err_ovf     <= w_ovf         | (r_err_ovf     & ~err_clr);
    end
  end

  assign s_ready        = w_s_ready;
  assign ifmap_data_B2M = r_ifmap;
  assign fltr_data_B2M  = r_fltr;
  assign psum_data_B2M  = r_psum;
  assign tag_out        = r_tag;
  assign caster_en      = r_cen;
  assign busy           = (r_state == ST_DRIVE);
  assign m_valid        = !w_empty;
  assign m_data         = w_head;
  assign err_type       = r_err_type;
  assign err_timeout    = r_err_timeout;
  assign err_ovf        = r_err_ovf;

endmodule
